// File: rtl/mult_cell_pkg.sv
// mult_cell_pkg: shared definitions for the pipelined multiply cell.
//   - op_e           : operation encoding (low half / high half variants)
//   - is_signed_a/b  : operand signedness decode per operation
//   - legality bounds for DATA_W and PIPE_STAGES
package mult_cell_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,   // low half, sign-agnostic
        OP_MULXUU = 2'b01,   // high half, unsigned x unsigned
        OP_MULXSU = 2'b10,   // high half, signed src1 x unsigned src2
        OP_MULXSS = 2'b11    // high half, signed x signed
    } op_e;

    localparam int DATA_W_MIN      = 8;
    localparam int DATA_W_MAX      = 64;
    localparam int PIPE_STAGES_MIN = 1;
    localparam int PIPE_STAGES_MAX = 4;

    function automatic logic is_signed_a(input op_e op);
        return (op == OP_MULXSU) || (op == OP_MULXSS);
    endfunction

    function automatic logic is_signed_b(input op_e op);
        return (op == OP_MULXSS);
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// mult_pipe_stage: one valid/ready register slice with a generic payload.
//   clk, reset_n          : clock, async active-low reset
//   flush                 : clears the valid bit at the next edge
//   in_valid/in_ready     : upstream handshake (in_ready = slice can advance)
//   in_data               : payload captured when advancing with valid input
//   out_valid/out_ready   : downstream handshake
//   out_data              : registered payload
module mult_pipe_stage
    import mult_cell_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Slice may take new data when empty or when its content leaves this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            // Data only loads with a real operation so a drained slice keeps
            // its last value (deterministic result when out_valid is low).
            if (in_valid)
                data_q <= in_data;
        end
    end

endmodule

// File: rtl/mult_cell_pipe.sv
// mult_cell_pipe: pipelined DATA_W x DATA_W integer multiply cell.
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_ready     : operation handshake (in_ready combinational
//                           from out_ready and flush)
//   op, src1, src2        : operation select and operands
//   flush                 : cancels every in-flight operation
//   out_valid/out_ready   : result handshake
//   result                : selected product half (last-stage register)
//   busy                  : any stage holds a valid operation
// Build option: MULT_CELL_HI_EN enables the high-half operations; without
// it only the low half is built and op is ignored.
module mult_cell_pipe
    import mult_cell_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              busy
);

    localparam int H = DATA_W / 2;

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX || (DATA_W % 2) != 0 ||
        PIPE_STAGES < PIPE_STAGES_MIN || PIPE_STAGES > PIPE_STAGES_MAX) begin : g_bad_param
        $error("mult_cell_pipe: illegal DATA_W/PIPE_STAGES");
    end

    // Operands split into half-width chunks: src = {hi, lo}.
    logic [H-1:0] al, ah, bl, bh;
    assign al = src1[H-1:0];
    assign ah = src1[DATA_W-1:H];
    assign bl = src2[H-1:0];
    assign bh = src2[DATA_W-1:H];

`ifdef MULT_CELL_HI_EN
    // Signed extension to DATA_W+1 bits means a = a_u - s_a*2^W. Modulo 2^2W
    // the signed product is a_u*b_u - 2^W*(s_a*b_u + s_b*a_u), so the sign
    // handling collapses into one correction subtracted from the high half.
    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] ll, lh, hl, hh, corr;
    } pp_t;
`else
    // Low half only needs lo*lo fully and the low chunks of the cross terms.
    typedef struct packed {
        logic [DATA_W-1:0] ll;
        logic [H-1:0]      lh, hl;
    } pp_t;
`endif

    localparam int PP_W = $bits(pp_t);

    pp_t [PIPE_STAGES-1:0] pl;     // pl[0] combinational, pl[i] = stage i-1 out
    pp_t                   pp_in;
    logic [PIPE_STAGES-1:0] vld, rdy;
    logic [DATA_W-1:0]      sum_res;

`ifdef MULT_CELL_HI_EN
    always_comb begin
        pp_in      = '0;
        pp_in.op   = op_e'(op);
        pp_in.ll   = DATA_W'(al) * DATA_W'(bl);
        pp_in.lh   = DATA_W'(al) * DATA_W'(bh);
        pp_in.hl   = DATA_W'(ah) * DATA_W'(bl);
        pp_in.hh   = DATA_W'(ah) * DATA_W'(bh);
        pp_in.corr = (is_signed_a(op_e'(op)) ? src2 : '0) +
                     (is_signed_b(op_e'(op)) ? src1 : '0);
    end

    // Final addition feeds the last stage. Bits above 2W cannot reach result.
    logic [2*DATA_W-1:0] prod;
    always_comb begin
        prod = {{DATA_W{1'b0}}, pl[PIPE_STAGES-1].ll}
             + {{H{1'b0}}, pl[PIPE_STAGES-1].lh, {H{1'b0}}}
             + {{H{1'b0}}, pl[PIPE_STAGES-1].hl, {H{1'b0}}}
             + {pl[PIPE_STAGES-1].hh, {DATA_W{1'b0}}}
             - {pl[PIPE_STAGES-1].corr, {DATA_W{1'b0}}};
        sum_res = (pl[PIPE_STAGES-1].op == OP_MUL) ? prod[DATA_W-1:0]
                                                   : prod[2*DATA_W-1:DATA_W];
    end
`else
    logic unused_op;
    assign unused_op = ^op;

    always_comb begin
        pp_in    = '0;
        pp_in.ll = DATA_W'(al) * DATA_W'(bl);
        pp_in.lh = al * bh;        // truncates to the low chunk
        pp_in.hl = ah * bl;
    end

    assign sum_res = pl[PIPE_STAGES-1].ll +
                     {pl[PIPE_STAGES-1].lh + pl[PIPE_STAGES-1].hl, {H{1'b0}}};
`endif

    assign pl[0] = pp_in;

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        logic s_in_valid, s_out_ready;

        if (i == 0) begin : g_first
            assign s_in_valid = in_valid;
        end else begin : g_mid
            assign s_in_valid = vld[i-1];
        end

        if (i == PIPE_STAGES-1) begin : g_last
            assign s_out_ready = out_ready;
            mult_pipe_stage #(.W(DATA_W)) u_stage (
                .clk       (clk),
                .reset_n   (reset_n),
                .flush     (flush),
                .in_valid  (s_in_valid),
                .in_ready  (rdy[i]),
                .in_data   (sum_res),
                .out_valid (vld[i]),
                .out_ready (s_out_ready),
                .out_data  (result)
            );
        end else begin : g_pp
            assign s_out_ready = rdy[i+1];
            mult_pipe_stage #(.W(PP_W)) u_stage (
                .clk       (clk),
                .reset_n   (reset_n),
                .flush     (flush),
                .in_valid  (s_in_valid),
                .in_ready  (rdy[i]),
                .in_data   (pl[i]),
                .out_valid (vld[i]),
                .out_ready (s_out_ready),
                .out_data  (pl[i+1])
            );
        end
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = vld[PIPE_STAGES-1];
    assign busy      = |vld;

endmodule

// File: tb/tb_mult_cell_pipe.sv
module tb_mult_cell_pipe;
    import mult_cell_pkg::*;

    logic        clk, reset_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [1:0]  op;
    logic [31:0] src1, src2, result;
    int n_checks = 0;
    int n_pass   = 0;

`ifdef MULT_CELL_HI_EN
    localparam logic [31:0] E_XUU_1 = 32'h0000_0001;
    localparam logic [31:0] E_XUU_F = 32'hFFFF_FFFE;
    localparam logic [31:0] E_XSU_F = 32'hFFFF_FFFF;
    localparam logic [31:0] E_XSS_F = 32'h0000_0000;
    localparam logic [31:0] E_LOW2  = 32'h0000_0001;
`else
    // Without the high-half build every op behaves as MUL.
    localparam logic [31:0] E_XUU_1 = 32'h0000_0000;
    localparam logic [31:0] E_XUU_F = 32'h0000_0001;
    localparam logic [31:0] E_XSU_F = 32'h0000_0001;
    localparam logic [31:0] E_XSS_F = 32'h0000_0001;
    localparam logic [31:0] E_LOW2  = 32'hFFFF_FFFE;
`endif

    mult_cell_pipe #(.DATA_W(32), .PIPE_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one op for a single cycle, check it shows up exactly two cycles
    // after the acceptance cycle with the expected value.
    task automatic run1(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        in_valid = 1'b1; op = o; src1 = a; src2 = b;
        tick();
        in_valid = 1'b0;
        chk({tag, "_early"}, {31'b0, out_valid}, 32'd0);
        tick();
        chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_res"}, result, exp);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_result",    result,             32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        reset_n = 1'b1;
        tick();

        run1("mul_2p16",   OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        run1("xuu_2p16",   OP_MULXUU, 32'h0001_0000, 32'h0001_0000, E_XUU_1);
        run1("xuu_ones",   OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, E_XUU_F);
        run1("xsu_ones",   OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, E_XSU_F);
        run1("xss_ones",   OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, E_XSS_F);
        run1("mul_ones",   OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        tick();

        // Backpressure: out_ready low for four cycles, four MULs back to back.
        out_ready = 1'b0;
        in_valid = 1'b1; op = OP_MUL; src1 = 32'd3; src2 = 32'd5;
        #1;
        chk("bp_rdy_a0", {31'b0, in_ready}, 32'd1);
        tick();
        src1 = 32'd7; src2 = 32'd11;
        chk("bp_rdy_a1", {31'b0, in_ready}, 32'd1);
        chk("bp_vld_a1", {31'b0, out_valid}, 32'd0);
        tick();
        src1 = 32'd13; src2 = 32'd17;
        chk("bp_rdy_full", {31'b0, in_ready}, 32'd0);
        chk("bp_vld_full", {31'b0, out_valid}, 32'd1);
        chk("bp_res_15a", result, 32'd15);
        tick();
        chk("bp_res_15b", result, 32'd15);
        chk("bp_rdy_stall", {31'b0, in_ready}, 32'd0);
        chk("bp_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("bp_res_15c", result, 32'd15);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", {31'b0, in_ready}, 32'd1);
        tick();
        src1 = 32'd19; src2 = 32'd23;
        chk("bp_vld_77", {31'b0, out_valid}, 32'd1);
        chk("bp_res_77", result, 32'd77);
        tick();
        in_valid = 1'b0;
        chk("bp_res_221", result, 32'd221);
        tick();
        chk("bp_res_437", result, 32'd437);
        tick();
        chk("bp_drained", {31'b0, out_valid}, 32'd0);

        // Flush with two ops in flight and a third offered.
        in_valid = 1'b1; op = OP_MUL; src1 = 32'd1; src2 = 32'd1;
        tick();
        src1 = 32'd2; src2 = 32'd2;
        tick();
        chk("fl_vld_pre", {31'b0, out_valid}, 32'd1);
        chk("fl_res_pre", result, 32'd1);
        src1 = 32'd9; src2 = 32'd9; flush = 1'b1;
        #1;
        chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("fl_still_empty", {31'b0, out_valid}, 32'd0);
        run1("fl_after", OP_MUL, 32'd6, 32'd7, 32'd42);
        tick();

        // Asynchronous reset with the pipeline full.
        in_valid = 1'b1; op = OP_MUL; src1 = 32'h0000_FFFF; src2 = 32'h0000_FFFF;
        tick();
        src1 = 32'd3; src2 = 32'd3;
        tick();
        in_valid = 1'b0;
        chk("rm_vld_pre", {31'b0, out_valid}, 32'd1);
        chk("rm_res_pre", result, 32'hFFFE_0001);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rm_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rm_busy", {31'b0, busy}, 32'd0);
        chk("rm_result", result, 32'd0);
        #3;
        reset_n = 1'b1;
        tick();
        chk("rm_in_ready", {31'b0, in_ready}, 32'd1);
        run1("rm_after", OP_MUL, 32'd2, 32'd2, 32'd4);
        tick();

        run1("low_half_xuu", OP_MULXUU, 32'hFFFF_FFFF, 32'h0000_0002, E_LOW2);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_cell_pipe.md
# mult_cell_pipe

Parametrised, pipelined integer multiply cell for the CPU's M-stage multiply path. It computes either the low half or, optionally, the signed/unsigned high half of a DATA_W×DATA_W product. A valid/ready handshake provides backpressure and a flush input cancels in-flight operations. It generalises the fixed 32-bit, low-half-only, fixed-latency multiply cell with configurable width and depth, high-half operations, stall support and flush.

## Interface
- DATA_W, 32, operand/result width; even, 8..64
- PIPE_STAGES, 2, latency in cycles; 1..4
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  cell accepts operation this cycle
- op  in  2  00 MUL (low), 01 MULXUU, 10 MULXSU, 11 MULXSS (high half)
- src1  in  DATA_W  multiplicand (signed for MULXSS/MULXSU)
- src2  in  DATA_W  multiplier (signed for MULXSS only)
- flush  in  1  synchronous cancel of all in-flight operations
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  DATA_W  product half selected by op
- busy  out  1  any stage holds a valid operation

## Operation
- Accept when in_valid && in_ready. Transfer out when out_valid && out_ready.
- Arithmetic:
  - Operands are extended to DATA_W+1 bits: sign-extended if signed for the op, else zero-extended.
  - The product is formed at 2·DATA_W+2 bits.
  - MUL returns bits [DATA_W-1:0]. MULX* return bits [2·DATA_W-1:DATA_W].
  - MUL is sign-agnostic.
- Pipeline is PIPE_STAGES register slices, each holding {valid, op, partial data}.
  - Partial products are split into DATA_W/2-bit chunks across stages.
  - Final addition happens in the last stage.
- Stage i advances when !valid_i || ready_{i+1}. The last stage's ready is out_ready. in_ready = (!valid_0 || ready_1) && !flush.
- Throughput is one operation per cycle with no bubbles under continuous out_ready.
- Results leave in acceptance order. Nothing is dropped or duplicated.
- flush: all valid bits clear at the next edge. in_ready is low in the flush cycle, so simultaneous in_valid is not accepted. out_valid is low the cycle after. A transfer on the flush cycle itself completes normally.
- result holds its value while out_valid && !out_ready. Outside a valid result, its value is don't-care but deterministic (last-stage register).
- Reset (asynchronous, any time, including mid-operation): all valids 0, all data registers 0, out_valid=0, result=0, busy=0, in_ready=1 after deassertion.

## Timing
- Latency: an operation accepted at edge N presents out_valid after edge N+PIPE_STAGES-1, i.e. visible PIPE_STAGES cycles after the acceptance cycle, assuming no stall.
- Backpressure: with out_ready low, at most PIPE_STAGES operations are held. in_ready falls in the same cycle the first stage cannot advance (combinational through the ready chain).
- in_ready is combinational from out_ready and flush. No other outputs depend combinationally on inputs.
- busy = OR of stage valids (registered).

## Configuration
- MULT_CELL_HI_EN defined:
  - All four ops are supported.
  - The full 2·DATA_W+2 product is built.
- MULT_CELL_HI_EN undefined:
  - Only the low half is built: lo×lo full, plus lo×hi and hi×lo low chunks.
  - op is ignored and every operation behaves as MUL.
  - Port list is unchanged.

## Structure
- Shared package mult_cell_pkg:
  - op encoding enum (MUL, MULXUU, MULXSU, MULXSS)
  - is_signed_a/is_signed_b decode functions
  - PIPE_STAGES/DATA_W legality constants
- Sub-module mult_pipe_stage: one valid/ready register slice (valid, op, data payload, generic width), instantiated PIPE_STAGES times.

## Test plan
- DATA_W=32, PIPE_STAGES=2, out_ready=1:
  - MUL 0x0001_0000×0x0001_0000 → 0x0000_0000.
  - MULXUU same operands → 0x0000_0001.
  - out_valid two cycles after acceptance.
- MULXUU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE; MULXSU same → 0xFFFF_FFFF; MULXSS same → 0x0000_0000; MUL same → 0x0000_0001.
- Back-to-back ops 3×5, 7×11, 13×17, 19×23 (MUL) with out_ready low for 4 cycles:
  - in_ready drops after 2 accepts.
  - Results 15, 77, 221, 437 emerge in order, each held stable while stalled.
- Two ops in flight, flush pulsed with in_valid high:
  - Next cycle out_valid=0, busy=0.
  - The offered op is not accepted.
  - A following op 6×7 returns 42.
- reset_n asserted mid-pipeline: out_valid, busy, result immediately 0. After release, 2×2 → 4.
- Build without MULT_CELL_HI_EN, op=MULXUU, 0xFFFF_FFFF×0x2 → 0xFFFF_FFFE (low half).
